// File: rtl/dm_arbiter.sv
// Shares one single-port data memory between the CPU port (0) and the loader port (1):
// per-cycle grant, round-robin ties, bounded bursts, and in-order read-return routing.
module dm_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4,
    parameter int RD_LAT    = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_req,
    input  logic          r0_wen,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_wen,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic [AW-1:0] m_add,
    output logic [DW-1:0] m_data_in,
    output logic          m_wen,
    input  logic [DW-1:0] m_data_out
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam int             CW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0]  BMAX = CW'(MAX_BURST - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_burst_cnt, w_burst_nxt;
    logic          r_rr_last;
    logic          w_gnt, w_sel, w_own_x, w_req_x, w_req_y, w_same;
    logic          w_sel_wen, w_rd_issue;
    logic          w_ret_vld, w_ret_port;
    logic [DW-1:0] r_hold0, r_hold1;

    // Port selection; grants are forced off while reset is asserted
    always_comb begin
        w_gnt   = 1'b0;
        w_sel   = 1'b0;
        w_own_x = (r_state == OWN1);
        w_req_x = w_own_x ? r1_req : r0_req;
        w_req_y = w_own_x ? r0_req : r1_req;
        case (r_state)
            OWN0, OWN1: begin
                if (w_req_x && (!w_req_y || (r_burst_cnt < BMAX))) begin
                    w_gnt = 1'b1;
                    w_sel = w_own_x;
                end else if (w_req_y) begin
                    w_gnt = 1'b1;
                    w_sel = ~w_own_x;
                end
            end
            default: begin
                if (r0_req && r1_req) begin
                    w_gnt = 1'b1;
                    w_sel = ~r_rr_last;
                end else if (r0_req) begin
                    w_gnt = 1'b1;
                end else if (r1_req) begin
                    w_gnt = 1'b1;
                    w_sel = 1'b1;
                end
            end
        endcase
        if (!rst_n) w_gnt = 1'b0;
    end

    always_comb begin
        w_state_nxt = IDLE;
        w_burst_nxt = '0;
        w_same      = (r_state == OWN0 && !w_sel) || (r_state == OWN1 && w_sel);
        if (w_gnt) begin
            w_state_nxt = w_sel ? OWN1 : OWN0;
            if (w_same) w_burst_nxt = (r_burst_cnt == BMAX) ? r_burst_cnt : r_burst_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_rr_last   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            if (w_gnt) r_rr_last <= w_sel;
        end
    end

    assign r0_gnt     = w_gnt & ~w_sel;
    assign r1_gnt     = w_gnt &  w_sel;
    assign w_sel_wen  = w_sel ? r1_wen : r0_wen;
    assign w_rd_issue = w_gnt & ~w_sel_wen;

    assign m_wen      = w_gnt & w_sel_wen;
    assign m_add      = r0_gnt ? r0_addr  : (r1_gnt ? r1_addr  : '0);
    assign m_data_in  = r0_gnt ? r0_wdata : (r1_gnt ? r1_wdata : '0);

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign w_ret_vld  = w_rd_issue;
            assign w_ret_port = w_sel;
        end else begin : g_pipe
            // Tag pipe tracks which port owns the data dm presents RD_LAT cycles later
            logic [RD_LAT-1:0] r_vld_pipe;
            logic [RD_LAT-1:0] r_port_pipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld_pipe  <= '0;
                    r_port_pipe <= '0;
                end else begin
                    r_vld_pipe[0]  <= w_rd_issue;
                    r_port_pipe[0] <= w_sel;
                    for (int i = 1; i < RD_LAT; i++) begin
                        r_vld_pipe[i]  <= r_vld_pipe[i-1];
                        r_port_pipe[i] <= r_port_pipe[i-1];
                    end
                end
            end
            assign w_ret_vld  = r_vld_pipe[RD_LAT-1];
            assign w_ret_port = r_port_pipe[RD_LAT-1];
        end
    endgenerate

    assign r0_rvalid = w_ret_vld & ~w_ret_port;
    assign r1_rvalid = w_ret_vld &  w_ret_port;
    assign r0_rdata  = r0_rvalid ? m_data_out : r_hold0;
    assign r1_rdata  = r1_rvalid ? m_data_out : r_hold1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold0 <= '0;
            r_hold1 <= '0;
        end else begin
            if (r0_rvalid) r_hold0 <= m_data_out;
            if (r1_rvalid) r_hold1 <= m_data_out;
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed + randomized bench for dm_arbiter: one instance with RD_LAT=2 and one with
// RD_LAT=0, both driven by the same requesters, each with its own dm model.
module tb_dm_arbiter;
    localparam int MB = 4;

    typedef struct {
        int          port;
        int          due;
        logic [31:0] data;
    } ret_t;

    logic        clk = 1'b0, rst_n = 1'b0, mem_init = 1'b1;
    logic        r0_req = 0, r0_wen = 0, r1_req = 0, r1_wen = 0;
    logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, m_wen;
    logic [31:0] r0_rdata, r1_rdata, m_add, m_data_in, m_data_out;
    logic        z0_gnt, z0_rvalid, z1_gnt, z1_rvalid, zm_wen;
    logic [31:0] z0_rdata, z1_rdata, zm_add, zm_data_in, zm_data_out;

    logic [31:0] mem2 [16];
    logic [31:0] mem0 [16];
    logic [31:0] ref_mem [16];
    logic [31:0] d1, d2;
    int          cyc = 0;
    int          n_cmp = 0, n_bad = 0;
    ret_t        rq [$];

    dm_arbiter #(.AW(32), .DW(32), .MAX_BURST(MB), .RD_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_wen(r0_wen), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_wen(r1_wen), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .m_add(m_add), .m_data_in(m_data_in), .m_wen(m_wen), .m_data_out(m_data_out)
    );

    dm_arbiter #(.AW(32), .DW(32), .MAX_BURST(MB), .RD_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_wen(r0_wen), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(z0_gnt), .r0_rvalid(z0_rvalid), .r0_rdata(z0_rdata),
        .r1_req(r1_req), .r1_wen(r1_wen), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(z1_gnt), .r1_rvalid(z1_rvalid), .r1_rdata(z1_rdata),
        .m_add(zm_add), .m_data_in(zm_data_in), .m_wen(zm_wen), .m_data_out(zm_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dm models: contents start as 0x00,0x11,..,0xFF; the RD_LAT=2 one registers data twice
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (mem_init) begin
                mem2[i] <= 32'(i * 17);
                mem0[i] <= 32'(i * 17);
            end
        end
        if (!mem_init && m_wen)  mem2[m_add[3:0]]  <= m_data_in;
        if (!mem_init && zm_wen) mem0[zm_add[3:0]] <= zm_data_in;
        d1 <= mem2[m_add[3:0]];
        d2 <= d1;
    end
    assign m_data_out  = d2;
    assign zm_data_out = mem0[zm_add[3:0]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs;
        r0_req = 0; r1_req = 0; r0_wen = 0; r1_wen = 0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'(i * 17);
        rst_n = 0; mem_init = 1; idle_reqs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, m_wen, z0_gnt, z1_gnt, z0_rvalid, z1_rvalid, zm_wen} !== 10'd0) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 0", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, m_wen, z0_gnt, z1_gnt, z0_rvalid, z1_rvalid, zm_wen});
        end
        n_cmp++;
        if ((m_add | m_data_in | r0_rdata | r1_rdata | zm_add | z0_rdata) !== 32'd0) begin
            n_bad++; $display("FAIL reset_data: add=%h din=%h rd0=%h rd1=%h want all 0", m_add, m_data_in, r0_rdata, r1_rdata);
        end
        tick();
        rst_n = 1; mem_init = 0;
        r0_req = 1; r0_wen = 0; r0_addr = 3; r1_req = 1; r1_wen = 0; r1_addr = 4;
        @(negedge clk);
        n_cmp++;
        if ({r1_gnt, r0_gnt} !== 2'b01 || m_add !== 32'd3) begin
            n_bad++; $display("FAIL reset_first_tie: gnt=%b add=%h want 01/3", {r1_gnt, r0_gnt}, m_add);
        end
        n_cmp++;
        if (z0_rvalid !== 1'b1 || z0_rdata !== 32'h33) begin
            n_bad++; $display("FAIL lat0_read: rvalid=%b rdata=%h want 1/33", z0_rvalid, z0_rdata);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({r1_gnt, r0_gnt} !== 2'b01) begin
            n_bad++; $display("FAIL reset_burst: gnt=%b want 01", {r1_gnt, r0_gnt});
        end
        rst_n = 0;
        #1;
        n_cmp++;
        if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, m_wen, z0_gnt, z1_gnt, z0_rvalid, z1_rvalid} !== 9'd0 ||
            (m_add | m_data_in | r0_rdata | r1_rdata | z0_rdata) !== 32'd0) begin
            n_bad++; $display("FAIL reset_mid: gnt=%b%b rv=%b%b add=%h rd0=%h want 0", r1_gnt, r0_gnt, r1_rvalid, r0_rvalid, m_add, r0_rdata);
        end
        tick();
        idle_reqs();
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({r0_rvalid, r1_rvalid} !== 2'b00 || r0_rdata !== 32'd0) begin
                n_bad++; $display("FAIL reset_drop_inflight[%0d]: rv=%b rd0=%h want 00/0", i, {r0_rvalid, r1_rvalid}, r0_rdata);
            end
            tick();
        end
    endtask

    task automatic test_single_port;
        r0_req = 1; r0_wen = 1; r0_addr = 2; r0_wdata = 12;
        @(negedge clk);
        n_cmp++;
        if (r0_gnt !== 1'b1 || m_wen !== 1'b1 || m_add !== 32'd2 || m_data_in !== 32'd12) begin
            n_bad++; $display("FAIL sp_write: gnt=%b wen=%b add=%h din=%h want 1/1/2/c", r0_gnt, m_wen, m_add, m_data_in);
        end
        ref_mem[2] = 12;
        tick();
        r0_wen = 0;
        @(negedge clk);
        n_cmp++;
        if (r0_gnt !== 1'b1 || m_wen !== 1'b0 || m_add !== 32'd2) begin
            n_bad++; $display("FAIL sp_read: gnt=%b wen=%b add=%h want 1/0/2", r0_gnt, m_wen, m_add);
        end
        n_cmp++;
        if (z0_rvalid !== 1'b1 || z0_rdata !== 32'd12) begin
            n_bad++; $display("FAIL sp_lat0: rvalid=%b rdata=%h want 1/c", z0_rvalid, z0_rdata);
        end
        tick();
        r0_req = 0;
        @(negedge clk);
        n_cmp++;
        if (r0_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL sp_early: rvalid=%b want 0", r0_rvalid);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 32'd12) begin
            n_bad++; $display("FAIL sp_return: rvalid=%b rdata=%h want 1/c", r0_rvalid, r0_rdata);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (r0_rvalid !== 1'b0 || r0_rdata !== 32'd12 || z0_rdata !== 32'd12) begin
            n_bad++; $display("FAIL sp_hold: rvalid=%b rdata=%h zrdata=%h want 0/c/c", r0_rvalid, r0_rdata, z0_rdata);
        end
        n_cmp++;
        if ({r1_gnt, r1_rvalid} !== 2'b00 || r1_rdata !== 32'd0) begin
            n_bad++; $display("FAIL sp_port1_quiet: gnt/rv=%b rdata=%h want 00/0", {r1_gnt, r1_rvalid}, r1_rdata);
        end
        tick();
    endtask

    task automatic test_tie;
        logic [9:0] pat;
        pat = 10'b0011110000;
        rst_n = 0;
        tick();
        rst_n = 1;
        r0_req = 1; r0_wen = 0; r0_addr = 0; r1_req = 1; r1_wen = 0; r1_addr = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({r1_gnt, r0_gnt} !== (pat[i] ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL tie_seq[%0d]: gnt=%b want %b", i, {r1_gnt, r0_gnt}, pat[i] ? 2'b10 : 2'b01);
            end
            tick();
        end
        idle_reqs();
        repeat (4) tick();
    endtask

    task automatic test_owner_drop;
        logic [1:0] want;
        r0_req = 1; r0_wen = 0; r0_addr = 7;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({r1_gnt, r0_gnt} !== 2'b01) begin
                n_bad++; $display("FAIL drop_own0[%0d]: gnt=%b want 01", i, {r1_gnt, r0_gnt});
            end
            tick();
        end
        r0_req = 0; r1_req = 1; r1_wen = 0; r1_addr = 8;
        @(negedge clk);
        n_cmp++;
        if ({r1_gnt, r0_gnt} !== 2'b10 || m_add !== 32'd8) begin
            n_bad++; $display("FAIL drop_switch: gnt=%b add=%h want 10/8", {r1_gnt, r0_gnt}, m_add);
        end
        tick();
        r0_req = 1;
        for (int i = 0; i < 4; i++) begin
            want = (i < 3) ? 2'b10 : 2'b01;
            @(negedge clk);
            n_cmp++;
            if ({r1_gnt, r0_gnt} !== want) begin
                n_bad++; $display("FAIL drop_burst_restart[%0d]: gnt=%b want %b", i, {r1_gnt, r0_gnt}, want);
            end
            tick();
        end
        idle_reqs();
        repeat (4) tick();
    endtask

    task automatic test_back_to_back;
        r0_req = 1; r0_wen = 0; r0_addr = 5;
        @(negedge clk);
        n_cmp++;
        if (r0_gnt !== 1'b1 || z0_rvalid !== 1'b1 || z0_rdata !== 32'h55) begin
            n_bad++; $display("FAIL b2b_gnt0: gnt=%b zrv=%b zrd=%h want 1/1/55", r0_gnt, z0_rvalid, z0_rdata);
        end
        tick();
        r0_req = 0; r1_req = 1; r1_wen = 0; r1_addr = 6;
        @(negedge clk);
        n_cmp++;
        if (r1_gnt !== 1'b1 || {r0_rvalid, r1_rvalid} !== 2'b00) begin
            n_bad++; $display("FAIL b2b_gnt1: gnt=%b rv=%b want 1/00", r1_gnt, {r0_rvalid, r1_rvalid});
        end
        tick();
        r1_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({r1_rvalid, r0_rvalid} !== 2'b01 || r0_rdata !== 32'h55) begin
            n_bad++; $display("FAIL b2b_ret0: rv=%b rd0=%h want 01/55", {r1_rvalid, r0_rvalid}, r0_rdata);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({r1_rvalid, r0_rvalid} !== 2'b10 || r1_rdata !== 32'h66) begin
            n_bad++; $display("FAIL b2b_ret1: rv=%b rd1=%h want 10/66", {r1_rvalid, r0_rvalid}, r1_rdata);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({r1_rvalid, r0_rvalid} !== 2'b00 || r0_rdata !== 32'h55 || r1_rdata !== 32'h66) begin
            n_bad++; $display("FAIL b2b_after: rv=%b rd0=%h rd1=%h want 00/55/66", {r1_rvalid, r0_rvalid}, r0_rdata, r1_rdata);
        end
        tick();
    endtask

    task automatic test_random;
        logic        p0, p1, w0, w1, g0, g1, ev0, ev1, ez0, ez1;
        logic [31:0] a0, a1, wd0, wd1, last0, last1, zl0, zl1, ea, ed;
        int          wait0, wait1;
        ret_t        e;
        p0 = 0; p1 = 0; w0 = 0; w1 = 0; a0 = 0; a1 = 0; wd0 = 0; wd1 = 0;
        last0 = 0; last1 = 0; zl0 = 0; zl1 = 0; wait0 = 0; wait1 = 0;
        idle_reqs();
        rst_n = 0;
        tick();
        rst_n = 1;
        rq.delete();
        for (int c = 0; c < 10000; c++) begin
            if (c >= 9990) begin
                p0 = 0; p1 = 0; wait0 = 0; wait1 = 0;
            end else begin
                if (p0 && $urandom_range(49) == 0) begin
                    p0 = 0; wait0 = 0;
                end else if (!p0 && $urandom_range(2) != 0) begin
                    p0 = 1; w0 = 1'($urandom_range(1)); a0 = {28'd0, 4'($urandom)}; wd0 = $urandom;
                end
                if (p1 && $urandom_range(49) == 0) begin
                    p1 = 0; wait1 = 0;
                end else if (!p1 && $urandom_range(2) != 0) begin
                    p1 = 1; w1 = 1'($urandom_range(1)); a1 = {28'd0, 4'($urandom)}; wd1 = $urandom;
                end
            end
            r0_req = p0; r0_wen = w0; r0_addr = a0; r0_wdata = wd0;
            r1_req = p1; r1_wen = w1; r1_addr = a1; r1_wdata = wd1;
            @(negedge clk);
            g0 = (r0_gnt === 1'b1);
            g1 = (r1_gnt === 1'b1);
            n_cmp++;
            if ({r1_gnt, r0_gnt} === 2'b11) begin
                n_bad++; $display("FAIL rnd_onehot c=%0d: gnt=11 want <=1 hot", c);
            end
            n_cmp++;
            if ((g0 && !p0) || (g1 && !p1) || ((p0 || p1) && !(g0 || g1))) begin
                n_bad++; $display("FAIL rnd_grant_legal c=%0d: gnt=%b%b req=%b%b", c, g1, g0, p1, p0);
            end
            n_cmp++;
            if ({z1_gnt, z0_gnt} !== {g1, g0}) begin
                n_bad++; $display("FAIL rnd_lat0_gnt c=%0d: got %b want %b", c, {z1_gnt, z0_gnt}, {g1, g0});
            end
            ea = g0 ? a0 : (g1 ? a1 : 32'd0);
            ed = g0 ? wd0 : (g1 ? wd1 : 32'd0);
            n_cmp++;
            if (m_add !== ea || m_data_in !== ed || m_wen !== ((g0 && w0) || (g1 && w1))) begin
                n_bad++; $display("FAIL rnd_dm_bus c=%0d: add=%h din=%h wen=%b want %h/%h/%b", c, m_add, m_data_in, m_wen, ea, ed, (g0 && w0) || (g1 && w1));
            end
            ev0 = (rq.size() > 0) && (rq[0].due == cyc) && (rq[0].port == 0);
            ev1 = (rq.size() > 0) && (rq[0].due == cyc) && (rq[0].port == 1);
            n_cmp++;
            if ({r1_rvalid, r0_rvalid} !== {ev1, ev0}) begin
                n_bad++; $display("FAIL rnd_rvalid c=%0d: got %b want %b", c, {r1_rvalid, r0_rvalid}, {ev1, ev0});
            end
            if (ev0 || ev1) begin
                e = rq.pop_front();
                if (ev0) last0 = e.data;
                else     last1 = e.data;
            end
            n_cmp++;
            if (r0_rdata !== last0 || r1_rdata !== last1) begin
                n_bad++; $display("FAIL rnd_rdata c=%0d: got %h/%h want %h/%h", c, r0_rdata, r1_rdata, last0, last1);
            end
            ez0 = g0 && !w0;
            ez1 = g1 && !w1;
            if (ez0) zl0 = ref_mem[a0[3:0]];
            if (ez1) zl1 = ref_mem[a1[3:0]];
            n_cmp++;
            if ({z1_rvalid, z0_rvalid} !== {ez1, ez0} || z0_rdata !== zl0 || z1_rdata !== zl1) begin
                n_bad++; $display("FAIL rnd_lat0_ret c=%0d: rv=%b rd=%h/%h want %b %h/%h", c, {z1_rvalid, z0_rvalid}, z0_rdata, z1_rdata, {ez1, ez0}, zl0, zl1);
            end
            if (p0 && !g0) wait0++;
            if (p1 && !g1) wait1++;
            n_cmp++;
            if (wait0 > MB || wait1 > MB) begin
                n_bad++; $display("FAIL rnd_starve c=%0d: waits %0d/%0d want <= %0d", c, wait0, wait1, MB);
            end
            if (g0) begin
                if (w0) ref_mem[a0[3:0]] = wd0;
                else    rq.push_back('{0, cyc + 2, ref_mem[a0[3:0]]});
                p0 = 0; wait0 = 0;
            end
            if (g1) begin
                if (w1) ref_mem[a1[3:0]] = wd1;
                else    rq.push_back('{1, cyc + 2, ref_mem[a1[3:0]]});
                p1 = 0; wait1 = 0;
            end
            tick();
        end
        n_cmp++;
        if (rq.size() != 0) begin
            n_bad++; $display("FAIL rnd_drain: %0d reads never returned, want 0", rq.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_tie();
        test_owner_drop();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
